// File: rtl/stream_arbiter_if.sv
// Requester-side and streamer-side signals of the byte arbiter, bundled as one port.
// master drives requests and watches grants; slave is the arbiter itself.
interface stream_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] reqData;
  logic [NREQ-1:0]   ack;
  logic              strmEn;
  logic [7:0]        strmData;
  logic [2:0]        grantId;
  logic              busy;
  logic              frameDone;

  modport master (
    output req, reqData,
    input  ack, strmEn, strmData, grantId, busy, frameDone
  );

  modport slave (
    input  req, reqData,
    output ack, strmEn, strmData, grantId, busy, frameDone
  );
endinterface

// File: rtl/stream_arbiter.sv
// Round-robin byte arbiter for one serial streamer: a req seen in IDLE is loaded/acked next cycle.
// Each frame occupies LOAD + 9 SEND cycles + GAP idle cycles; req is ignored until IDLE returns.
module stream_arbiter #(
  parameter int NREQ = 4,
  parameter int GAP  = 1
) (
  input  logic            clk,
  input  logic            rst,
  stream_arbiter_if.slave bus
);
  localparam int         IW       = $clog2(NREQ);
  localparam logic [3:0] GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, LOAD, SEND, GAPW} state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] win;
  logic          any;
  logic [7:0]    win_byte;
  logic [3:0]    scnt;
  logic [3:0]    gcnt;

  // Search starts at ptr and wraps; the first requester found wins.
  always_comb begin
    logic [IW-1:0] cand;
    any  = 1'b0;
    win  = '0;
    cand = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IW'((int'(ptr) + k) % NREQ);
      if (!any && bus.req[cand]) begin
        any = 1'b1;
        win = cand;
      end
    end
  end

  always_comb begin
    win_byte = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IW'(i) == win) win_byte = bus.reqData[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      ptr           <= '0;
      scnt          <= '0;
      gcnt          <= '0;
      bus.ack       <= '0;
      bus.strmEn    <= 1'b0;
      bus.strmData  <= '0;
      bus.grantId   <= '0;
      bus.busy      <= 1'b0;
      bus.frameDone <= 1'b0;
    end else begin
      bus.ack       <= '0;
      bus.strmEn    <= 1'b0;
      bus.frameDone <= 1'b0;
      case (state)
        IDLE: begin
          if (any) begin
            state        <= LOAD;
            bus.ack[win] <= 1'b1;
            bus.strmEn   <= 1'b1;
            bus.strmData <= win_byte;
            bus.grantId  <= 3'(win);
            bus.busy     <= 1'b1;
            ptr          <= (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
          end
        end
        LOAD: begin
          state <= SEND;
          scnt  <= '0;
        end
        SEND: begin
          // frameDone is registered, so it is raised one cycle ahead of the last bit cycle.
          scnt          <= scnt + 1'b1;
          bus.frameDone <= (scnt == 4'd7);
          if (scnt == 4'd8) begin
            scnt <= '0;
            if (GAP == 0) begin
              state    <= IDLE;
              bus.busy <= 1'b0;
            end else begin
              state <= GAPW;
              gcnt  <= '0;
            end
          end
        end
        GAPW: begin
          if (gcnt == GAP_LAST) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
            gcnt     <= '0;
          end else begin
            gcnt <= gcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_stream_arbiter.sv
// Directed bench for stream_arbiter: one instance with GAP=1, one with GAP=0, shared clk/rst.
// Cycle n is the clock period following the n-th edge after the scenario's start.
module tb_stream_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   last1 = -1;
  int   last0 = -1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  stream_arbiter_if #(.NREQ(4)) bus1 ();
  stream_arbiter_if #(.NREQ(4)) bus0 ();

  stream_arbiter #(.NREQ(4), .GAP(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  stream_arbiter #(.NREQ(4), .GAP(0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    bus1.req  = '0;
    bus0.req  = '0;
    step();
    step();
  endtask

  task automatic wait_idle(input string tag, input bit on_dut0);
    for (int i = 0; i < 40; i++) begin
      if (!(on_dut0 ? bus0.busy : bus1.busy)) break;
      step();
    end
    chk(tag, on_dut0 ? bus0.busy : bus1.busy, 1'b0);
  endtask

  // Spacing between loads on either instance; a reset legitimately restarts the count.
  always @(negedge clk) begin
    if (rst) begin
      last1 = -1;
      last0 = -1;
    end else begin
      if (bus1.strmEn) begin
        if (last1 >= 0) chk("spacing_dut1", (cyc - last1) >= 11, 1'b1);
        last1 = cyc;
      end
      if (bus0.strmEn) begin
        if (last0 >= 0) chk("spacing_dut0", (cyc - last0) >= 11, 1'b1);
        last0 = cyc;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, compared=%0d", n_cmp);
    $fatal(1);
  end

  initial begin
    logic [2:0] exp_b [5];
    int         ng;
    int         t_prev;

    exp_b = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
    bus1.reqData = '0;
    bus0.reqData = '0;
    do_reset();

    chk("rst_ack",       bus1.ack,       4'b0000);
    chk("rst_strmEn",    bus1.strmEn,    1'b0);
    chk("rst_strmData",  bus1.strmData,  8'h00);
    chk("rst_grantId",   bus1.grantId,   3'd0);
    chk("rst_busy",      bus1.busy,      1'b0);
    chk("rst_frameDone", bus1.frameDone, 1'b0);

    // Single request from requester 2
    bus1.reqData = 32'h00A5_0000;
    bus1.req     = 4'b0100;
    rst          = 1'b0;
    step();
    chk("A_strmEn",   bus1.strmEn,   1'b1);
    chk("A_strmData", bus1.strmData, 8'hA5);
    chk("A_ack",      bus1.ack,      4'b0100);
    chk("A_grantId",  bus1.grantId,  3'd2);
    chk("A_busy1",    bus1.busy,     1'b1);
    bus1.req = '0;
    step();
    chk("A_strmEn_c2", bus1.strmEn, 1'b0);
    chk("A_ack_c2",    bus1.ack,    4'b0000);
    repeat (7) step();
    chk("A_fd_c9",   bus1.frameDone, 1'b0);
    step();
    chk("A_fd_c10",  bus1.frameDone, 1'b1);
    chk("A_busy10",  bus1.busy,      1'b1);
    step();
    chk("A_fd_c11",  bus1.frameDone, 1'b0);
    chk("A_busy11",  bus1.busy,      1'b1);
    chk("A_gid_hold", bus1.grantId,  3'd2);
    step();
    chk("A_busy12",  bus1.busy,      1'b0);

    // All four requesting, each dropping req for the cycle of its ack
    do_reset();
    bus1.reqData = 32'h4433_2211;
    bus1.req     = 4'b1111;
    rst          = 1'b0;
    ng     = 0;
    t_prev = 0;
    for (int c = 1; c <= 80 && ng < 5; c++) begin
      step();
      if (bus1.strmEn) begin
        chk("B_grant", bus1.grantId, exp_b[ng]);
        chk("B_ack",   bus1.ack,     4'b0001 << exp_b[ng]);
        if (ng > 0) chk("B_spacing", c - t_prev, 12);
        t_prev = c;
        ng++;
      end
      bus1.req = 4'b1111 & ~bus1.ack;
    end
    chk("B_count", ng, 5);
    bus1.req = '0;
    wait_idle("B_idle", 1'b0);

    // Data and req changes during a frame must not disturb it
    do_reset();
    bus1.reqData = 32'h7700_3C00;
    bus1.req     = 4'b0010;
    rst          = 1'b0;
    step();
    chk("C_strmEn",   bus1.strmEn,   1'b1);
    chk("C_ack",      bus1.ack,      4'b0010);
    chk("C_grantId",  bus1.grantId,  3'd1);
    chk("C_strmData", bus1.strmData, 8'h3C);
    bus1.req = '0;
    step();
    step();
    bus1.reqData = 32'h7700_FF00;
    bus1.req     = 4'b1000;
    for (int c = 4; c <= 12; c++) begin
      step();
      chk("C_no_ack", bus1.ack, 4'b0000);
      chk("C_no_en",  bus1.strmEn, 1'b0);
    end
    chk("C_gid_hold", bus1.grantId, 3'd1);
    step();
    chk("C2_strmEn",   bus1.strmEn,   1'b1);
    chk("C2_grantId",  bus1.grantId,  3'd3);
    chk("C2_ack",      bus1.ack,      4'b1000);
    chk("C2_strmData", bus1.strmData, 8'h77);
    bus1.req = '0;
    wait_idle("C_idle", 1'b0);

    // Reset in the middle of a frame
    do_reset();
    bus1.reqData = 32'h1122_3344;
    bus1.req     = 4'b0100;
    rst          = 1'b0;
    step();
    chk("D_grantId", bus1.grantId, 3'd2);
    bus1.req = '0;
    repeat (4) step();
    rst = 1'b1;
    step();
    chk("D_busy",      bus1.busy,      1'b0);
    chk("D_frameDone", bus1.frameDone, 1'b0);
    chk("D_strmEn",    bus1.strmEn,    1'b0);
    chk("D_grantId0",  bus1.grantId,   3'd0);
    rst      = 1'b0;
    bus1.req = 4'b1010;
    step();
    chk("D2_strmEn",   bus1.strmEn,   1'b1);
    chk("D2_ack",      bus1.ack,      4'b0010);
    chk("D2_grantId",  bus1.grantId,  3'd1);
    chk("D2_strmData", bus1.strmData, 8'h33);
    bus1.req = '0;
    repeat (3) step();
    chk("D_no_fd_c10", bus1.frameDone, 1'b0);
    wait_idle("D_idle", 1'b0);

    // Persistent single requester on the GAP=0 instance
    do_reset();
    bus0.reqData = 32'h0000_005A;
    bus0.req     = 4'b0001;
    rst          = 1'b0;
    chk("E_busy_c0", bus0.busy, 1'b0);
    for (int c = 1; c <= 45; c++) begin
      step();
      chk("E_ack",  bus0.ack,  (c % 11 == 1) ? 4'b0001 : 4'b0000);
      chk("E_busy", bus0.busy, (c % 11 == 0) ? 1'b0 : 1'b1);
    end
    bus0.req = '0;
    wait_idle("E_idle", 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/stream_arbiter.md
STREAM_ARBITER -- requirements
Module: stream_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of byte requesters sharing one serial streaming output (2..8).
REQ-002 Parameter GAP, default 1, idle cycles inserted after each frame before next grant (0..15).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 req  input  NREQ  per-requester request, level; held high with data stable until ack.
REQ-006 reqData  input  8*NREQ  requester bytes; requester i occupies bits [8i+7:8i].
REQ-007 ack  output  NREQ  one-cycle pulse to requester i when its byte is loaded into the streamer.
REQ-008 strmEn  output  1  load pulse to streamer inEn.
REQ-009 strmData  output  8  byte to streamer dIn, valid while strmEn=1.
REQ-010 grantId  output  3  index of requester owning current frame; holds last value when idle.
REQ-011 busy  output  1  high from load cycle through final GAP cycle.
REQ-012 frameDone  output  1  one-cycle pulse in last serial bit cycle of a frame.

Function
REQ-013 All outputs SHALL be registered.
REQ-014 FSM states SHALL be IDLE, LOAD, SEND, GAPW; no other reachable states.
REQ-015 IDLE: if any req bit high, select winner by round-robin, capture its byte and index, go LOAD; else stay IDLE.
REQ-016 Round-robin: search starts at pointer ptr, ascending with wrap at NREQ-1 -> 0; first high req wins.
REQ-017 ptr SHALL update to (winner+1) mod NREQ on each grant, only on grant.
REQ-018 LOAD (exactly one cycle): strmEn=1, strmData=captured byte, ack[winner]=1, busy=1; next state SEND.
REQ-019 SEND SHALL last exactly 9 cycles (streamer frame = 10 bit cycles: marker 1, pad 0, d7..d0, counting LOAD cycle); frameDone=1 in 9th SEND cycle.
REQ-020 After SEND: GAPW for GAP cycles, then IDLE; GAP=0 goes SEND -> IDLE directly.
REQ-021 Latency: req high in IDLE cycle t -> strmEn and ack at t+1; minimum spacing between strmEn pulses = 11+GAP cycles.
REQ-022 strmEn SHALL never assert while a frame is in progress (LOAD, SEND, GAPW); overlapping loads are forbidden.
REQ-023 req SHALL be ignored outside IDLE; req changes during LOAD/SEND/GAPW do not affect the current frame.
REQ-024 reqData SHALL be sampled only at the IDLE->LOAD transition; later changes do not alter strmData.
REQ-025 req still high in IDLE after an ack SHALL be treated as a new request (requester deasserts on ack).
REQ-026 Simultaneous requests: exactly one ack per frame; losers keep req and are served in later frames in round-robin order.
REQ-027 A single persistently requesting client SHALL be granted every frame slot.
REQ-028 ack, strmEn, frameDone SHALL each be high for exactly one cycle per frame.

Reset
REQ-029 rst high at an edge SHALL force: state IDLE, ptr=0, grantId=0, ack=0, strmEn=0, strmData=0, busy=0, frameDone=0, SEND/GAP counters 0.
REQ-030 rst mid-frame SHALL abort the frame without frameDone or further ack; the streamer shares rst and aborts likewise.
REQ-031 rst has priority over all requests in the same cycle; first grant possible one cycle after rst deasserts.

Verification
REQ-032 NREQ=4, GAP=1, req=0100, reqData[23:16]=0xA5 at cycle 0 -> cycle 1 strmEn=1, strmData=0xA5, ack=0100, grantId=2; frameDone at cycle 10; busy low at cycle 12.
REQ-033 req=1111 held continuously, each requester dropping req for one cycle after its ack -> grant order 0,1,2,3,0; strmEn pulses 12 cycles apart.
REQ-034 req=0001 held permanently, GAP=0 -> ack[0] every 11 cycles, no other ack, busy low one cycle between frames.
REQ-035 Grant to 1 at cycle 1; change reqData[15:8] and raise req[3] during SEND -> streamer output carries original byte; req[3] granted next slot.
REQ-036 rst pulsed in SEND cycle 4 -> next cycle busy=0, no frameDone; req=0010 after reset -> ack[1] (ptr reset to 0, 1 is first high).
REQ-037 Checker: across all scenarios, no strmEn within 10 cycles of the previous strmEn.
